// File: rtl/display_scan_sched.sv
// Time-multiplexed scan scheduler for a shared common-anode seven-segment bus.
// Each digit owns one slot per frame; every slot opens with blank cycles, then PWM-lit cycles.
module display_scan_sched #(
  parameter int NDIGITS  = 2,
  parameter int SLOTBITS = 3,
  parameter int BLANKCYC = 1,
  localparam int IDXW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   digits_in,
  input  logic [SLOTBITS-1:0]    brightness,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     digit_en,
  output logic [IDXW-1:0]        slot_idx,
  output logic                   frame_start
);

  logic [SLOTBITS-1:0]  cnt;
  logic [IDXW-1:0]      idx;
  logic [4*NDIGITS-1:0] pend;
  logic                 pend_v;
  logic [4*NDIGITS-1:0] act;

  logic                 lit;
  logic [SLOTBITS:0]    lit_off;
  logic [3:0]           cur_digit;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot counter and digit index; both collapse to zero whenever scanning stops.
  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == {SLOTBITS{1'b1}}) begin
        if (idx == IDXW'(NDIGITS - 1)) idx <= '0;
        else                           idx <= idx + 1'b1;
      end
    end
  end

  // Double buffer: a load landing on the frame boundary edge refills pend after the swap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend   <= '0;
      pend_v <= 1'b0;
      act    <= '0;
    end else begin
      if (frame_start && pend_v) begin
        act    <= pend;
        pend_v <= 1'b0;
      end
      if (load) begin
        pend   <= digits_in;
        pend_v <= 1'b1;
      end
    end
  end

  always_comb begin
    lit_off     = {1'b0, cnt} - (SLOTBITS + 1)'(BLANKCYC);
    lit         = reset_n && en && (cnt >= SLOTBITS'(BLANKCYC)) &&
                  (lit_off < {1'b0, brightness});
    cur_digit   = act[4*idx +: 4];
    frame_start = reset_n && en && (cnt == '0) && (idx == '0);
    slot_idx    = idx;
    digit_en    = '0;
    seg         = 7'h7F;
    if (lit) begin
      digit_en = NDIGITS'(1) << idx;
      seg      = hex7(cur_digit);
    end
  end

endmodule
